// File: rtl/fp_divsqrt_arbiter_if.sv
// ---------------------------------------------------------------------------
// fp_divsqrt_arbiter_if
//   Bundles every handshake and data signal around fp_divsqrt_arbiter:
//   the requester ports (req_*/rsp_*) and the link to the shared fp_unit
//   (fp_*).
//
//   modport slave  : used by the arbiter itself
//   modport master : used by the environment (requesters + fp_unit)
//
//   req_valid/req_ready   per-requester job handshake, one bit each
//   req_data1/2, rm, op   per-requester job fields, slice i = requester i
//   fp_data1/2, rm        operands presented to fp_unit
//   fp_fdiv/fp_fsqrt      op select, meaningful only with fp_enable
//   fp_enable             one-cycle start strobe to fp_unit
//   fp_ready/result/flags completion from fp_unit
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_result/flags      shared response payload
//   rsp_timeout           response came from the watchdog, not fp_unit
// ---------------------------------------------------------------------------
interface fp_divsqrt_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_data1;
    logic [32*NREQ-1:0]   req_data2;
    logic [3*NREQ-1:0]    req_rm;
    logic [2*NREQ-1:0]    req_op;

    logic [31:0]          fp_data1;
    logic [31:0]          fp_data2;
    logic [2:0]           fp_rm;
    logic                 fp_fdiv;
    logic                 fp_fsqrt;
    logic                 fp_enable;
    logic                 fp_ready;
    logic [31:0]          fp_result;
    logic [4:0]           fp_flags;

    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [31:0]          rsp_result;
    logic [4:0]           rsp_flags;
    logic                 rsp_timeout;

    modport slave (
        input  req_valid, req_data1, req_data2, req_rm, req_op,
        output req_ready,
        output fp_data1, fp_data2, fp_rm, fp_fdiv, fp_fsqrt, fp_enable,
        input  fp_ready, fp_result, fp_flags,
        output rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_data1, req_data2, req_rm, req_op,
        input  req_ready,
        input  fp_data1, fp_data2, fp_rm, fp_fdiv, fp_fsqrt, fp_enable,
        output fp_ready, fp_result, fp_flags,
        input  rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        output rsp_ready
    );
endinterface

// File: rtl/fp_divsqrt_arbiter.sv
// ---------------------------------------------------------------------------
// fp_divsqrt_arbiter
//   Shares one fp_unit divide/square-root datapath among NREQ requesters.
//   Jobs are granted round-robin, issued to fp_unit with a one-cycle enable,
//   and the result (or a watchdog quiet-NaN) is returned to the owner.
//   One job is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
//   clock   rising-edge clock
//   reset   synchronous, active-high; aborts any job in progress
//   bus     fp_divsqrt_arbiter_if.slave (requester, fp_unit and response
//           signals; see the interface file for the per-signal summary)
//
//   Parameters: NREQ (1..4) requesters, TIMEOUT (2..255) WAIT cycles
//   before a job is aborted with a timeout response.
// ---------------------------------------------------------------------------
module fp_divsqrt_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    fp_divsqrt_arbiter_if.slave   bus
);

    localparam int          PTR_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [4:0]  FLAG_NV    = 5'h10;
    localparam logic [7:0]  TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0]  OP_FDIV    = 2'b01;
    localparam logic [1:0]  OP_FSQRT   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [7:0]         timer_q;
    logic [31:0]        data1_q, data2_q;
    logic [2:0]         rm_q;
    logic               fdiv_q, fsqrt_q;
    logic [31:0]        result_q;
    logic [4:0]         flags_q;
    logic               timeout_q;

    // Round-robin selection and the granted requester's job fields.
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [31:0]        sel_data1, sel_data2;
    logic [2:0]         sel_rm;
    logic [1:0]         sel_op;
    logic               op_legal;
    logic               owner_rsp_ready;

    // FSM strobes consumed by the datapath registers.
    logic               accept, take_fp, take_timeout, rsp_done;

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path through the case/if tree can infer a latch.
    always_comb begin
        logic               found_hi;
        logic [PTR_W-1:0]   idx_hi, idx_any;
        found_hi    = 1'b0;
        idx_hi      = '0;
        idx_any     = '0;
        grant_found = 1'b0;
        // Descending scan: the last hit is the lowest index, so idx_hi is the
        // first requester at or above rr_ptr and idx_any the wrap-around pick.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                grant_found = 1'b1;
                idx_any     = PTR_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = PTR_W'(i);
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_any;

        sel_data1       = '0;
        sel_data2       = '0;
        sel_rm          = '0;
        sel_op          = '0;
        owner_rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(grant_idx) == i) begin
                sel_data1 = bus.req_data1[32*i +: 32];
                sel_data2 = bus.req_data2[32*i +: 32];
                sel_rm    = bus.req_rm[3*i +: 3];
                sel_op    = bus.req_op[2*i +: 2];
            end
            if (int'(owner_q) == i) begin
                owner_rsp_ready = bus.rsp_ready[i];
            end
        end
        op_legal = (sel_op == OP_FDIV) || (sel_op == OP_FSQRT);
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        take_fp      = 1'b0;
        take_timeout = 1'b0;
        rsp_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    accept  = 1'b1;
                    // Illegal op encodings never reach fp_unit.
                    state_d = op_legal ? ISSUE : RESP;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // fp_ready wins over a coincident timeout.
                if (bus.fp_ready) begin
                    take_fp = 1'b1;
                    state_d = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    take_timeout = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            timer_q   <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            rm_q      <= '0;
            fdiv_q    <= 1'b0;
            fsqrt_q   <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                owner_q <= grant_idx;
                data1_q <= sel_data1;
                // Divisor slot is zero for sqrt so fp_unit sees a clean operand.
                data2_q <= (sel_op == OP_FSQRT) ? 32'h0 : sel_data2;
                rm_q    <= sel_rm;
                fdiv_q  <= (sel_op == OP_FDIV);
                fsqrt_q <= (sel_op == OP_FSQRT);
                if (!op_legal) begin
                    result_q  <= QNAN;
                    flags_q   <= FLAG_NV;
                    timeout_q <= 1'b0;
                end
            end

            if (state_q == ISSUE) begin
                timer_q <= '0;
            end else if (state_q == WAIT) begin
                timer_q <= timer_q + 8'd1;
            end

            if (take_fp) begin
                result_q  <= bus.fp_result;
                flags_q   <= bus.fp_flags;
                timeout_q <= 1'b0;
            end else if (take_timeout) begin
                result_q  <= QNAN;
                flags_q   <= FLAG_NV;
                timeout_q <= 1'b1;
            end

            if (rsp_done) begin
                rr_ptr_q <= (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is asserted so an aborted job
    // cannot leak an enable or a response during the reset cycle.
    always_comb begin
        logic live;
        live            = !reset;
        bus.req_ready   = '0;
        bus.rsp_valid   = '0;
        bus.fp_enable   = live && (state_q == ISSUE);
        bus.fp_fdiv     = bus.fp_enable && fdiv_q;
        bus.fp_fsqrt    = bus.fp_enable && fsqrt_q;
        bus.fp_data1    = '0;
        bus.fp_data2    = '0;
        bus.fp_rm       = '0;
        bus.rsp_result  = '0;
        bus.rsp_flags   = '0;
        bus.rsp_timeout = 1'b0;

        if (live && (state_q == ISSUE || state_q == WAIT)) begin
            bus.fp_data1 = data1_q;
            bus.fp_data2 = data2_q;
            bus.fp_rm    = rm_q;
        end

        if (live && state_q == RESP) begin
            bus.rsp_result  = result_q;
            bus.rsp_flags   = flags_q;
            bus.rsp_timeout = timeout_q;
        end

        for (int i = 0; i < NREQ; i++) begin
            if (live && accept && int'(grant_idx) == i) begin
                bus.req_ready[i] = 1'b1;
            end
            if (live && state_q == RESP && int'(owner_q) == i) begin
                bus.rsp_valid[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_divsqrt_arbiter
//   Directed bench for fp_divsqrt_arbiter with NREQ=2, TIMEOUT=64. The bench
//   plays both requesters and the fp_unit; expected values are hand-computed
//   single-precision constants.
// ---------------------------------------------------------------------------
module tb_fp_divsqrt_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 64;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    fp_divsqrt_arbiter_if #(.NREQ(NREQ)) bus ();

    fp_divsqrt_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;

    // Counts fp_unit start strobes, sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.fp_enable) en_cnt <= en_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int i, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [2:0] rm, input logic [1:0] op);
        bus.req_valid[i]          = 1'b1;
        bus.req_data1[32*i +: 32] = d1;
        bus.req_data2[32*i +: 32] = d2;
        bus.req_rm[3*i +: 3]      = rm;
        bus.req_op[2*i +: 2]      = op;
    endtask

    // Presents a job from requester i, expects the grant this cycle, then
    // drops req_valid after the accepting edge.
    task automatic accept(input int i, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [2:0] rm, input logic [1:0] op);
        drive_req(i, d1, d2, rm, op);
        #1;
        check("req_ready_grant", 32'(bus.req_ready), 32'(1 << i));
        tick();
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic fp_reply(input logic [31:0] res, input logic [4:0] fl);
        bus.fp_ready  = 1'b1;
        bus.fp_result = res;
        bus.fp_flags  = fl;
        tick();
        bus.fp_ready  = 1'b0;
        bus.fp_result = '0;
        bus.fp_flags  = '0;
    endtask

    task automatic respond(input int i, input logic [31:0] res, input logic [4:0] fl,
                           input logic to);
        check("rsp_valid",   32'(bus.rsp_valid),   32'(1 << i));
        check("rsp_result",  bus.rsp_result,       res);
        check("rsp_flags",   32'(bus.rsp_flags),   32'(fl));
        check("rsp_timeout", 32'(bus.rsp_timeout), 32'(to));
        bus.rsp_ready[i] = 1'b1;
        #1;
        check("no_grant_in_resp", 32'(bus.req_ready), 32'h0);
        tick();
        bus.rsp_ready[i] = 1'b0;
        check("rsp_valid_cleared", 32'(bus.rsp_valid), 32'h0);
    endtask

    initial begin
        int e0;
        int n;

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data1 = '0;
        bus.req_data2 = '0;
        bus.req_rm    = '0;
        bus.req_op    = '0;
        bus.rsp_ready = '0;
        bus.fp_ready  = 1'b0;
        bus.fp_result = '0;
        bus.fp_flags  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state: every output low.
        check("rst_req_ready",  32'(bus.req_ready),  32'h0);
        check("rst_fp_enable",  32'(bus.fp_enable),  32'h0);
        check("rst_fp_data1",   bus.fp_data1,        32'h0);
        check("rst_rsp_valid",  32'(bus.rsp_valid),  32'h0);
        check("rst_rsp_result", bus.rsp_result,      32'h0);

        // 1. req0 fdiv 1.0 / 2.0 = 0.5
        e0 = en_cnt;
        accept(0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 2'b01);
        check("t1_enable", 32'(bus.fp_enable), 32'h1);
        check("t1_fdiv",   32'(bus.fp_fdiv),   32'h1);
        check("t1_fsqrt",  32'(bus.fp_fsqrt),  32'h0);
        check("t1_data1",  bus.fp_data1,       32'h3F80_0000);
        check("t1_data2",  bus.fp_data2,       32'h4000_0000);
        tick();
        check("t1_wait_enable", 32'(bus.fp_enable), 32'h0);
        check("t1_wait_fdiv",   32'(bus.fp_fdiv),   32'h0);
        check("t1_wait_data1",  bus.fp_data1,       32'h3F80_0000);
        fp_reply(32'h3F00_0000, 5'h00);
        respond(0, 32'h3F00_0000, 5'h00, 1'b0);
        check("t1_one_enable", 32'(en_cnt - e0), 32'd1);

        // 2. req1 fsqrt 4.0 = 2.0, divisor slot must read 0
        accept(1, 32'h4080_0000, 32'hDEAD_BEEF, 3'd1, 2'b10);
        check("t2_fsqrt", 32'(bus.fp_fsqrt), 32'h1);
        check("t2_fdiv",  32'(bus.fp_fdiv),  32'h0);
        check("t2_data1", bus.fp_data1,      32'h4080_0000);
        check("t2_data2", bus.fp_data2,      32'h0);
        check("t2_rm",    32'(bus.fp_rm),    32'd1);
        tick();
        fp_reply(32'h4000_0000, 5'h00);
        respond(1, 32'h4000_0000, 5'h00, 1'b0);

        // 3. Both valid with rr_ptr=0: req0 (3.0/1.0) then req1 (sqrt 9.0).
        drive_req(1, 32'h4110_0000, 32'h0, 3'd0, 2'b10);
        accept(0, 32'h4040_0000, 32'h3F80_0000, 3'd0, 2'b01);
        tick();
        fp_reply(32'h4040_0000, 5'h00);
        respond(0, 32'h4040_0000, 5'h00, 1'b0);
        accept(1, 32'h4110_0000, 32'h0, 3'd0, 2'b10);
        tick();
        fp_reply(32'h4040_0000, 5'h01);
        respond(1, 32'h4040_0000, 5'h01, 1'b0);

        // 4. rr_ptr back at 0: req0 alone is granted; fp_unit never answers.
        e0 = en_cnt;
        accept(0, 32'h3F80_0000, 32'h4040_0000, 3'd2, 2'b01);
        tick();
        check("t4_wait_data2", bus.fp_data2, 32'h4040_0000);
        n = 0;
        while (bus.rsp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", 32'(n), 32'd64);
        respond(0, 32'h7FC0_0000, 5'h10, 1'b1);
        check("t4_one_enable", 32'(en_cnt - e0), 32'd1);

        // 5 + 7. rr_ptr=1: req1 with illegal op wins over a pending req0;
        // response held while rsp_ready stays low, no new grant meanwhile.
        e0 = en_cnt;
        drive_req(0, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 2'b01);
        accept(1, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 2'b11);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t7_hold_valid",  32'(bus.rsp_valid), 32'h2);
            check("t7_hold_result", bus.rsp_result,     32'h7FC0_0000);
            check("t7_hold_flags",  32'(bus.rsp_flags), 32'h10);
            check("t7_no_grant",    32'(bus.req_ready), 32'h0);
        end
        check("t5_no_enable", 32'(en_cnt - e0), 32'd0);
        respond(1, 32'h7FC0_0000, 5'h10, 1'b0);

        // 6. req0 pending is granted; reset during WAIT aborts it.
        accept(0, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 2'b01);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t6_rst_enable", 32'(bus.fp_enable), 32'h0);
        tick();
        reset = 1'b0;
        check("t6_req_ready",  32'(bus.req_ready),  32'h0);
        check("t6_fp_enable",  32'(bus.fp_enable),  32'h0);
        check("t6_fp_data1",   bus.fp_data1,        32'h0);
        check("t6_fp_data2",   bus.fp_data2,        32'h0);
        check("t6_rsp_valid",  32'(bus.rsp_valid),  32'h0);
        check("t6_rsp_result", bus.rsp_result,      32'h0);
        fp_reply(32'h3F80_0000, 5'h00);
        check("t6_late_ready_valid", 32'(bus.rsp_valid), 32'h0);
        check("t6_late_ready_en",    32'(bus.fp_enable), 32'h0);
        tick();
        check("t6_still_idle", 32'(bus.rsp_valid), 32'h0);

        // Arbiter still serves after the abort: req1 sqrt 9.0 = 3.0.
        accept(1, 32'h4110_0000, 32'h0, 3'd4, 2'b10);
        check("t6_post_rm", 32'(bus.fp_rm), 32'd4);
        tick();
        fp_reply(32'h4040_0000, 5'h00);
        respond(1, 32'h4040_0000, 5'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
